sha256_digest_unloader: RTL
===========================

Name: sha256_digest_unloader

Overview:
- Read-side counterpart of the 64-bit load registers in the SHA-256 datapath.
- Captures the final 256-bit digest (H0..H7) on a single-cycle load strobe.
- Streams the digest out as NUM_WORDS words of WORD_W bits over a valid/ready handshake, most-significant word (H0||H1) first.
- Sits between the hash core and the host/output interface; provides busy, last and done status for the core controller.

Parameters:
- WORD_W, 64: width of each output word in bits.
- NUM_WORDS, 4: words per digest. Digest width is the derived localparam DIG_W = WORD_W*NUM_WORDS (256). Counter width is clog2(NUM_WORDS), minimum 1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- load  input  1  single-cycle strobe; digest_i is valid in this cycle.
- digest_i  input  DIG_W  digest from the hash core; bits [DIG_W-1 -: WORD_W] go out first.
- data_o  output  WORD_W  current output word.
- valid_o  output  1  data_o holds a valid word.
- ready_i  input  1  downstream accepts data_o this cycle.
- last_o  output  1  high together with valid_o on the final word of a digest.
- busy_o  output  1  high while a digest is held and not fully transferred.
- done_o  output  1  one-cycle pulse after the final word is accepted.
- overrun_o  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (RST=0, asynchronous, any state, including mid-transfer):
  - State goes to IDLE and the word counter to 0.
  - data_o, valid_o, last_o, busy_o, done_o and overrun_o all go to 0.
  - The internal shift register clears to 0 and the in-flight digest is lost.
- FSM states:
  - IDLE: valid_o=0, busy_o=0, data_o=0.
  - SEND: valid_o=1, busy_o=1.
- IDLE with load=1 at a rising edge:
  - Capture digest_i into the shift register, set counter=0, go to SEND.
  - valid_o=1 and data_o=digest_i[DIG_W-1 -: WORD_W] from the next cycle, so load-to-first-valid latency is 1 cycle.
- A transfer happens at a rising edge when valid_o=1 and ready_i=1.
  - On a transfer that is not the last: shift left by WORD_W, counter+1, next word is visible the following cycle.
- While valid_o=1 and ready_i=0, data_o, last_o and the counter hold stable.
  - valid_o never drops without a transfer, except on reset.
- last_o = valid_o AND (counter == NUM_WORDS-1).
- Final transfer (last_o=1, ready_i=1):
  - done_o=1 for exactly the next cycle.
  - Without a simultaneous load: go to IDLE, so valid_o=0, busy_o=0 and data_o=0 the next cycle.
  - With a simultaneous load: capture the new digest, counter=0, stay in SEND. The next cycle shows valid_o=1 with the new first word and done_o=1, giving back-to-back digests with no bubble.
- load in SEND other than on the final transfer:
  - The load is ignored and the current digest is unaffected.
  - overrun_o=1 for the next cycle.
- ready_i is don't-care in IDLE.
- A single digest needs a minimum of NUM_WORDS cycles after valid_o first rises (4 with the defaults).
- No combinational path from ready_i or load to any output; all outputs are registered.

Test Plan:
- Reset then load with digest_i=256'h0123456789ABCDEF_FEDCBA9876543210_1111111122222222_3333333344444444 and ready_i held 1.
  - Required: from the next cycle data_o is 0123456789ABCDEF, FEDCBA9876543210, 1111111122222222, 3333333344444444 on consecutive cycles, with last_o only on the 4th.
  - Required: done_o pulses the cycle after the 4th word, then valid_o=0 and busy_o=0.
- Same digest with ready_i toggling 1,0,0,1,0,1,1.
  - Required: each word is held stable while ready_i=0, exactly 4 transfers occur in order, and no word is duplicated or dropped.
- Load 0xAA..AA, then load 0x55..55 on the cycle the 4th word transfers.
  - Required: the next cycle shows valid_o=1, data_o=5555555555555555 and done_o=1.
  - Required: four 55.. words follow, then done_o again.
- Load 0xAA..AA, then assert load with 0xFF..FF while the 2nd word is pending.
  - Required: overrun_o pulses once and the remaining words are still AAAAAAAAAAAAAAAA.
- Drive RST=0 asynchronously mid-clock after 2 words have transferred.
  - Required: all outputs go to 0 immediately without waiting for a clock edge.
  - Required: after release, a fresh load of 0x0123..4444 streams all 4 words correctly from the first.
- Hold ready_i=0 for 20 cycles after a load.
  - Required: valid_o stays 1, data_o stays 0123456789ABCDEF, and busy_o stays 1.

Source files
------------

// File: rtl/sha256_digest_unloader.sv
// Captures a finished SHA-256 digest on a load strobe and streams it out
// word by word, most-significant word first, over a valid/ready handshake.
module sha256_digest_unloader #(
  parameter int WORD_W    = 64,
  parameter int NUM_WORDS = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        load,
  input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
  output logic [WORD_W-1:0]           data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        last_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overrun_o
);

  localparam int DIG_W = WORD_W * NUM_WORDS;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [DIG_W-1:0]   shift_reg, shift_next;
  logic               done_reg, done_next;
  logic               overrun_reg, overrun_next;

  logic xfer;
  logic is_last;

  assign xfer    = (state_reg == SEND) && ready_i;
  assign is_last = (cnt_reg == LAST_CNT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    done_next    = 1'b0;
    overrun_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          shift_next = digest_i;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (xfer && is_last) begin
          done_next = 1'b1;
          cnt_next  = '0;
          // A load coinciding with the final transfer chains the next digest with no bubble.
          if (load) begin
            shift_next = digest_i;
          end else begin
            shift_next = '0;
            state_next = IDLE;
          end
        end else begin
          if (xfer) begin
            shift_next = shift_reg << WORD_W;
            cnt_next   = cnt_reg + CNT_W'(1);
          end
          overrun_next = load;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        shift_next = '0;
      end
    endcase
  end

  // Outputs come straight from state registers; nothing from ready_i or load leaks through.
  assign data_o    = shift_reg[DIG_W-1 -: WORD_W];
  assign valid_o   = (state_reg == SEND);
  assign busy_o    = (state_reg == SEND);
  assign last_o    = (state_reg == SEND) && is_last;
  assign done_o    = done_reg;
  assign overrun_o = overrun_reg;

endmodule
